// File: rtl/ddr3_memtest.sv
// ddr3_memtest
//   Self-checking traffic generator for the ddr3_controller user port. On start it
//   writes a selectable pattern over the window BASE_ADDR .. BASE_ADDR+LEN-1. It then
//   reads every word back and compares it. Results are held until the next start or
//   reset: pass/fail, a saturating error count and the details of the first failure.
//
// Ports
//   pclk, rst            : clock shared with the controller, synchronous active-high reset
//   start, mode          : one-cycle run request and pattern select (latched at start)
//   busy, data_ready,
//   dout                 : controller status and read-data return
//   rd, wr, refresh,
//   addr, din            : controller command outputs (refresh is never requested)
//   running, done, pass  : run status
//   err_count,
//   first_err_addr,
//   first_err_data,
//   timeout_seen         : error reporting
module ddr3_memtest #(
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter int                    LEN        = 1024,
  parameter int                    TIMEOUT    = 20,
  parameter logic [DATA_WIDTH-1:0] SEED       = 16'hACE1,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 16'hB400
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  busy,
  input  logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd,
  output logic                  wr,
  output logic                  refresh,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  timeout_seen
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LEN - 1);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_WORD  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [DATA_WIDTH-1:0] SEED_INIT = (SEED == {DATA_WIDTH{1'b0}}) ? ONE_WORD : SEED;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_WAIT  = 3'd1,
    ST_WR_ISSUE = 3'd2,
    ST_WR_GAP   = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_ISSUE = 3'd5,
    ST_RD_DATA  = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // Galois right-shift LFSR step
  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] x);
    lfsr_next = x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
  endfunction

  // Walking-one step: rotate left so bit DATA_WIDTH-1 wraps back to bit 0
  function automatic logic [DATA_WIDTH-1:0] walk_next(input logic [DATA_WIDTH-1:0] x);
    walk_next = {x[DATA_WIDTH-2:0], x[DATA_WIDTH-1]};
  endfunction

  // Error counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? 16'hFFFF : (x + 16'd1);
  endfunction

  state_t                  state_r;
  logic [1:0]              mode_r;
  logic [IDX_W-1:0]        idx_r;
  logic [TMR_W-1:0]        timer_r;
  logic [DATA_WIDTH-1:0]   lfsr_r;
  logic [DATA_WIDTH-1:0]   walk_r;
  logic                    rd_r;
  logic                    wr_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   din_r;
  logic                    running_r;
  logic                    done_r;
  logic                    pass_r;
  logic [15:0]             err_cnt_r;
  logic [ADDR_WIDTH-1:0]   first_err_addr_r;
  logic [DATA_WIDTH-1:0]   first_err_data_r;
  logic                    timeout_seen_r;

  logic [ADDR_WIDTH-1:0]   cur_addr_s;
  logic [DATA_WIDTH-1:0]   addr_word_s;
  logic [DATA_WIDTH-1:0]   pattern_s;
  logic                    last_idx_s;
  logic                    rd_mismatch_s;
  logic                    rd_timeout_s;
  logic                    rd_err_s;
  logic                    rd_finish_s;

  assign cur_addr_s  = BASE_ADDR + ADDR_WIDTH'(idx_r);
  assign addr_word_s = DATA_WIDTH'(cur_addr_s);
  assign last_idx_s  = (idx_r == IDX_LAST);

  // Expected word for the current index in the latched mode; the write and read
  // passes walk the same generators, so both see identical sequences
  always_comb begin
    case (mode_r)
      2'd0:    pattern_s = addr_word_s;
      2'd1:    pattern_s = walk_r;
      2'd2:    pattern_s = lfsr_r;
      2'd3:    pattern_s = ~addr_word_s;
      default: pattern_s = addr_word_s;
    endcase
  end

  // Read outcome classification; data_ready wins over a timeout on the same cycle
  always_comb begin
    rd_mismatch_s = 1'b0;
    rd_timeout_s  = 1'b0;
    if (state_r == ST_RD_DATA) begin
      if (data_ready) begin
        rd_mismatch_s = (dout != pattern_s);
      end else begin
        rd_timeout_s = (timer_r == TIMER_LAST);
      end
    end else begin
      rd_mismatch_s = 1'b0;
      rd_timeout_s  = 1'b0;
    end
    rd_err_s    = rd_mismatch_s | rd_timeout_s;
    rd_finish_s = (state_r == ST_RD_DATA) & (data_ready | rd_timeout_s);
  end

  // Sequencer: state, pattern generators, command pulses and result registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      mode_r           <= 2'd0;
      idx_r            <= {IDX_W{1'b0}};
      timer_r          <= {TMR_W{1'b0}};
      lfsr_r           <= SEED_INIT;
      walk_r           <= ONE_WORD;
      rd_r             <= 1'b0;
      wr_r             <= 1'b0;
      addr_r           <= {ADDR_WIDTH{1'b0}};
      din_r            <= {DATA_WIDTH{1'b0}};
      running_r        <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_cnt_r        <= 16'h0000;
      first_err_addr_r <= {ADDR_WIDTH{1'b0}};
      first_err_data_r <= {DATA_WIDTH{1'b0}};
      timeout_seen_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_r           <= mode;
            idx_r            <= {IDX_W{1'b0}};
            timer_r          <= {TMR_W{1'b0}};
            lfsr_r           <= SEED_INIT;
            walk_r           <= ONE_WORD;
            running_r        <= 1'b1;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_cnt_r        <= 16'h0000;
            first_err_addr_r <= {ADDR_WIDTH{1'b0}};
            first_err_data_r <= {DATA_WIDTH{1'b0}};
            timeout_seen_r   <= 1'b0;
            state_r          <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (!busy) begin
            state_r <= ST_WR_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          // Command registers load together so wr, addr and din appear on the same cycle
          wr_r    <= 1'b1;
          addr_r  <= cur_addr_s;
          din_r   <= pattern_s;
          state_r <= ST_WR_GAP;
        end
        ST_WR_GAP: begin
          wr_r <= 1'b0;
          if (last_idx_s) begin
            idx_r   <= {IDX_W{1'b0}};
            lfsr_r  <= SEED_INIT;
            walk_r  <= ONE_WORD;
            state_r <= ST_RD_WAIT;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            lfsr_r  <= lfsr_next(lfsr_r);
            walk_r  <= walk_next(walk_r);
            state_r <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!busy) begin
            state_r <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          rd_r    <= 1'b1;
          addr_r  <= cur_addr_s;
          timer_r <= {TMR_W{1'b0}};
          state_r <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          rd_r <= 1'b0;
          if (rd_err_s) begin
            // Only the very first error of a run is recorded in detail
            if (err_cnt_r == 16'h0000) begin
              first_err_addr_r <= cur_addr_s;
              first_err_data_r <= rd_timeout_s ? {DATA_WIDTH{1'b0}} : dout;
            end
            err_cnt_r <= sat_inc(err_cnt_r);
          end
          if (rd_timeout_s) begin
            timeout_seen_r <= 1'b1;
          end
          if (rd_finish_s) begin
            timer_r <= {TMR_W{1'b0}};
            if (last_idx_s) begin
              running_r <= 1'b0;
              done_r    <= 1'b1;
              pass_r    <= (err_cnt_r == 16'h0000) && !rd_err_s;
              state_r   <= ST_DONE;
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              lfsr_r  <= lfsr_next(lfsr_r);
              walk_r  <= walk_next(walk_r);
              state_r <= ST_RD_WAIT;
            end
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: begin
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd             = rd_r;
  assign wr             = wr_r;
  assign refresh        = 1'b0;
  assign addr           = addr_r;
  assign din            = din_r;
  assign running        = running_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_cnt_r;
  assign first_err_addr = first_err_addr_r;
  assign first_err_data = first_err_data_r;
  assign timeout_seen   = timeout_seen_r;

endmodule

// File: tb/tb_ddr3_memtest.sv
// Bench for ddr3_memtest: a behavioural memory/controller model answers the DUT's
// commands, and every finished run is compared against results derived from the
// pattern rules and the faults the model injects.
module tb_ddr3_memtest;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int LEN = 18;
  localparam int TO = 20;
  localparam logic [AW-1:0] BASE = 26'h1000;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic busy = 1'b0;
  logic data_ready = 1'b0;
  logic [DW-1:0] dout = 16'h0000;
  logic rd, wr, refresh, running, done, pass, timeout_seen;
  logic [AW-1:0] addr, first_err_addr;
  logic [DW-1:0] din, first_err_data;
  logic [15:0] err_count;

  ddr3_memtest #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .LEN(LEN),
    .TIMEOUT(TO), .SEED(16'hACE1), .LFSR_TAPS(16'hB400)
  ) dut (
    .pclk(pclk), .rst(rst), .start(start), .mode(mode), .busy(busy),
    .data_ready(data_ready), .dout(dout), .rd(rd), .wr(wr), .refresh(refresh),
    .addr(addr), .din(din), .running(running), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .timeout_seen(timeout_seen)
  );

  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;

  // Memory / controller model state
  logic [DW-1:0] mem    [LEN];
  logic [DW-1:0] flip   [LEN];
  logic [DW-1:0] wr_log [LEN];
  int            lat    [LEN];
  int  widx, ridx, run_mode, pcnt, poff;
  bit  pend, force_busy, busy_rand, scramble;

  typedef struct {
    int          mode;
    int          kind;
    int          exp_err;
    bit          exp_pass;
    logic [25:0] exp_faddr;
    logic [15:0] exp_fdata;
    bit          exp_tseen;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pattern word i of a run, straight from the pattern rules
  function automatic logic [15:0] ref_pattern(input int m, input int i);
    logic [15:0] x;
    int a;
    a = int'(BASE) + i;
    case (m)
      0: ref_pattern = a[15:0];
      1: ref_pattern = 16'(1 << (i % 16));
      2: begin
        x = 16'hACE1;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        ref_pattern = x;
      end
      default: ref_pattern = ~a[15:0];
    endcase
  endfunction

  // One model step at the falling edge: observe commands, then drive the inputs
  task automatic model_step();
    if (rd || wr) check("rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
    if (wr) begin
      if (widx < LEN) begin
        check("wr_addr", addr, BASE + widx);
        check("wr_data", din, ref_pattern(run_mode, widx));
        mem[widx] = din;
        wr_log[widx] = din;
      end else begin
        check("wr_extra", widx, LEN - 1);
      end
      widx++;
    end
    if (rd) begin
      if (ridx < LEN) begin
        check("rd_addr", addr, BASE + ridx);
        pend = 1'b1;
        pcnt = lat[ridx];
        poff = ridx;
      end else begin
        check("rd_extra", ridx, LEN - 1);
      end
      ridx++;
    end
    data_ready = 1'b0;
    dout = 16'($urandom);
    if (rst) pend = 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        data_ready = 1'b1;
        dout = mem[poff] ^ flip[poff];
        pend = 1'b0;
      end else begin
        pcnt--;
      end
    end
    busy = force_busy | (busy_rand && ($urandom_range(0, 3) == 0));
  endtask

  task automatic tick();
    @(negedge pclk);
    model_step();
  endtask

  task automatic setup(input int kind);
    for (int i = 0; i < LEN; i++) begin
      flip[i] = 16'h0000;
      lat[i]  = $urandom_range(0, 4);
      mem[i]  = 16'h0000;
    end
    case (kind)
      1: flip[2] = 16'h0001;
      2: for (int i = 0; i < LEN; i++) lat[i] = 255;
      3: for (int i = 0; i < LEN; i++) lat[i] = TO - 1;
      4: lat[5] = TO;
      5: flip[0] = 16'h8000;
      6: flip[16] = 16'h0003;
      default: ;
    endcase
  endtask

  task automatic start_run(input int m);
    widx = 0;
    ridx = 0;
    pend = 1'b0;
    run_mode = m;
    mode = 2'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    bit finished;
    finished = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (scramble) begin
        mode = 2'($urandom);
        if ($urandom_range(0, 15) == 0) start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check("run_completes", {31'd0, finished}, 32'd1);
  endtask

  task automatic expect_result(input int e_err, input bit e_pass, input logic [25:0] e_faddr,
                               input logic [15:0] e_fdata, input bit e_tseen);
    check("done", {31'd0, done}, 32'd1);
    check("running_low", {31'd0, running}, 32'd0);
    check("pass", {31'd0, pass}, {31'd0, e_pass});
    check("err_count", {16'd0, err_count}, e_err);
    check("first_err_addr", {6'd0, first_err_addr}, {6'd0, e_faddr});
    check("first_err_data", {16'd0, first_err_data}, {16'd0, e_fdata});
    check("timeout_seen", {31'd0, timeout_seen}, {31'd0, e_tseen});
    check("write_count", widx, LEN);
    check("read_count", ridx, LEN);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"}, {31'd0, rd}, 32'd0);
    check({tag, "_wr"}, {31'd0, wr}, 32'd0);
    check({tag, "_refresh"}, {31'd0, refresh}, 32'd0);
    check({tag, "_addr"}, {6'd0, addr}, 32'd0);
    check({tag, "_din"}, {16'd0, din}, 32'd0);
    check({tag, "_running"}, {31'd0, running}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_err_count"}, {16'd0, err_count}, 32'd0);
    check({tag, "_first_err_addr"}, {6'd0, first_err_addr}, 32'd0);
    check({tag, "_first_err_data"}, {16'd0, first_err_data}, 32'd0);
    check({tag, "_timeout_seen"}, {31'd0, timeout_seen}, 32'd0);
  endtask

  initial begin
    int e_err;
    bit e_tseen, tmo, seen;
    logic [25:0] e_faddr;
    logic [15:0] e_fdata;

    tbl[0] = '{0, 0, 0,  1'b1, 26'h0,    16'h0,    1'b0};
    tbl[1] = '{0, 1, 1,  1'b0, 26'h1002, 16'h1003, 1'b0};
    tbl[2] = '{0, 2, 18, 1'b0, 26'h1000, 16'h0000, 1'b1};
    tbl[3] = '{3, 3, 0,  1'b1, 26'h0,    16'h0,    1'b0};
    tbl[4] = '{1, 4, 1,  1'b0, 26'h1005, 16'h0000, 1'b1};
    tbl[5] = '{2, 5, 1,  1'b0, 26'h1000, 16'h2CE1, 1'b0};
    tbl[6] = '{1, 6, 1,  1'b0, 26'h1010, 16'h0002, 1'b0};
    tbl[7] = '{2, 0, 0,  1'b1, 26'h0,    16'h0,    1'b0};

    force_busy = 1'b0; busy_rand = 1'b0; scramble = 1'b0;
    widx = 0; ridx = 0; run_mode = 0; pend = 1'b0; pcnt = 0; poff = 0;
    setup(0);
    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Directed table
    for (int t = 0; t < 8; t++) begin
      setup(tbl[t].kind);
      start_run(tbl[t].mode);
      finish_run(2000);
      expect_result(tbl[t].exp_err, tbl[t].exp_pass, tbl[t].exp_faddr,
                    tbl[t].exp_fdata, tbl[t].exp_tseen);
      if (tbl[t].mode == 2 && tbl[t].kind == 0) begin
        check("lfsr_word0", {16'd0, wr_log[0]}, 32'h0000ACE1);
        check("lfsr_word1", {16'd0, wr_log[1]}, 32'h0000E270);
      end
      if (tbl[t].mode == 1 && tbl[t].kind == 6) begin
        check("walk_word16", {16'd0, wr_log[16]}, 32'h00000001);
        check("walk_word17", {16'd0, wr_log[17]}, 32'h00000002);
      end
      repeat (3) tick();
      check("done_held", {31'd0, done}, 32'd1);
    end

    // Randomized runs against the reference rules
    busy_rand = 1'b1;
    scramble = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int m;
      m = $urandom_range(0, 3);
      setup(0);
      for (int i = 0; i < LEN; i++) begin
        int p;
        p = $urandom_range(0, 99);
        lat[i] = (p < 4) ? 255 : (p < 8) ? TO : $urandom_range(0, TO - 1);
        flip[i] = ($urandom_range(0, 9) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000;
      end
      e_err = 0; e_tseen = 1'b0; e_faddr = 26'h0; e_fdata = 16'h0;
      for (int i = 0; i < LEN; i++) begin
        tmo = (lat[i] >= TO);
        if (tmo || flip[i] != 16'h0000) begin
          if (e_err == 0) begin
            e_faddr = BASE + i;
            e_fdata = tmo ? 16'h0000 : (ref_pattern(m, i) ^ flip[i]);
          end
          e_err++;
          if (tmo) e_tseen = 1'b1;
        end
      end
      start_run(m);
      finish_run(3000);
      expect_result(e_err, (e_err == 0), e_faddr, e_fdata, e_tseen);
    end
    busy_rand = 1'b0;
    scramble = 1'b0;

    // busy held after start: no write until it drops, then wr two cycles later
    setup(0);
    force_busy = 1'b1;
    tick();
    start_run(0);
    for (int c = 0; c < 50; c++) begin
      if (c == 25) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("no_wr_while_busy", widx, 0);
    force_busy = 1'b0;
    tick();
    tick();
    check("wr_after_1_cycle", {31'd0, wr}, 32'd0);
    tick();
    check("wr_after_2_cycles", {31'd0, wr}, 32'd1);
    finish_run(2000);
    expect_result(0, 1'b1, 26'h0, 16'h0, 1'b0);

    // Reset during a read, then a clean rerun
    setup(0);
    for (int i = 0; i < LEN; i++) lat[i] = 10;
    start_run(0);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("rd_seen_before_reset", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    tick();
    check_zero("mid_reset");
    rst = 1'b0;
    tick();
    setup(0);
    start_run(0);
    finish_run(2000);
    expect_result(0, 1'b1, 26'h0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
